// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StAddr     = 4'd1,
    StAddrAck  = 4'd2,
    StPtr      = 4'd3,
    StPtrAck   = 4'd4,
    StWdata    = 4'd5,
    StWdataAck = 4'd6,
    StRdata    = 4'd7,
    StMack     = 4'd8,
    StIgnore   = 4'd9
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input synchronisers with edge, START and STOP pulse detection.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  // Reset to the idle-bus level so no edge is seen on reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl;
      sda_prev_q <= sda;
    end
  end

  assign scl       = scl_sync_q[SYNC_STAGES-1];
  assign sda       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_prev_q;
  assign scl_fall  = ~scl & scl_prev_q;
  assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with register pointer: writes to and reads from an external 256x8 bank.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h66,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       sda_oe_q, sda_oe_d;
  logic       reg_wr_en_q, reg_wr_en_d;
  logic       busy_q, busy_d;
  logic       byte_done;
  logic       rx_state;

  assign rx_state  = (state_q == StAddr) || (state_q == StPtr) || (state_q == StWdata);
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      sda_oe_q    <= 1'b0;
      reg_wr_en_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      sda_oe_q    <= sda_oe_d;
      reg_wr_en_q <= reg_wr_en_d;
      busy_q      <= busy_d;
    end
  end

  // busy is raised on an address match and held across repeated START until STOP.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    sda_oe_d    = sda_oe_q;
    reg_wr_en_d = 1'b0;
    busy_d      = busy_q;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      if (rx_state && scl_rise && (bit_cnt_q != 4'd8)) begin
        shift_d   = {shift_q[6:0], sda};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      unique case (state_q)
        StIdle: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        StAddr: begin
          if (byte_done) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = StAddrAck;
            end else begin
              busy_d  = 1'b0;
              state_d = StIgnore;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (shift_q[0] == I2C_RW_READ) begin
              shift_d  = reg_rdata;
              sda_oe_d = ~reg_rdata[7];
              state_d  = StRdata;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StPtr;
            end
          end
        end
        StPtr: begin
          if (byte_done) begin
            bit_cnt_d  = '0;
            reg_addr_d = shift_q;
            sda_oe_d   = 1'b1;
            state_d    = StPtrAck;
          end
        end
        StPtrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StWdata;
          end
        end
        StWdata: begin
          if (byte_done) begin
            bit_cnt_d   = '0;
            sda_oe_d    = 1'b1;
            reg_wdata_d = shift_q;
            reg_wr_en_d = 1'b1;
            state_d     = StWdataAck;
          end
        end
        StWdataAck: begin
          if (scl_fall) begin
            sda_oe_d   = 1'b0;
            reg_addr_d = reg_addr_q + 8'd1;
            state_d    = StWdata;
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = StMack;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StMack: begin
          if (scl_rise) begin
            reg_addr_d = reg_addr_q + 8'd1;
            if (sda) begin
              busy_d  = 1'b0;
              state_d = StIgnore;
            end
          end else if (scl_fall) begin
            shift_d   = reg_rdata;
            sda_oe_d  = ~reg_rdata[7];
            bit_cnt_d = '0;
            state_d   = StRdata;
          end
        end
        StIgnore: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr_en = reg_wr_en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: I2C master BFM at clk/16, pull-up bus, 256x8 bank, scoreboard.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int Q = 40;  // quarter SCL period; clk period is 10

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_i, sda_i, sda_oe, reg_wr_en, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register bank model, initialised to addr ^ 0x5A.
  logic [7:0] bank [256];
  assign reg_rdata = bank[reg_addr];
  initial begin
    for (int i = 0; i < 256; i++) bank[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (reg_wr_en) bank[reg_addr] = reg_wdata;
    end
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_wr = 0;
  int          viol = 0;
  logic        oe_seen = 1'b0;
  logic        busy_seen = 1'b0;
  logic        exp_ack [$];
  logic [7:0]  exp_rd [$];
  logic [15:0] exp_wr [$];
  logic        ack_obs;
  logic [7:0]  rd_obs;
  event        ack_ev, rd_ev;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got an event, want none", name);
  endtask

  // Monitors: pop expected responses whenever the DUT presents one.
  initial forever begin
    @(ack_ev);
    if (exp_ack.size() == 0) fail_now("unexpected ack slot");
    else check("ack bit", 16'(ack_obs), 16'(exp_ack.pop_front()));
  end

  initial forever begin
    @(rd_ev);
    if (exp_rd.size() == 0) fail_now("unexpected read byte");
    else check("read byte", 16'(rd_obs), 16'(exp_rd.pop_front()));
  end

  initial begin
    logic oe_prev;
    oe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && reg_wr_en) begin
        n_wr++;
        if (exp_wr.size() == 0) fail_now("unexpected reg_wr_en");
        else check("write addr/data", {reg_addr, reg_wdata}, exp_wr.pop_front());
      end
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (sda_oe && !oe_prev && scl_i) viol++;
      oe_prev = sda_oe;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Master BFM
  task automatic bus_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #(2 * Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b;    #Q;
    m_scl = 1'b1; #Q;
    s = sda_i;    #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic want_ack);
    logic s;
    exp_ack.push_back(want_ack);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack_obs = s;
    ->ack_ev;
  endtask

  task automatic recv_byte(input logic [7:0] want, input logic nack);
    logic [7:0] v;
    logic       s;
    exp_rd.push_back(want);
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      v[i] = s;
    end
    clock_bit(nack, s);
    rd_obs = v;
    ->rd_ev;
  endtask

  task automatic settle_and_drain(input string name);
    repeat (4) @(negedge clk);
    check({name, " queues drained"}, 16'(exp_ack.size() + exp_rd.size() + exp_wr.size()), 16'd0);
  endtask

  task automatic write_test(input string name);
    int wr0;
    wr0 = n_wr;
    busy_seen = 1'b0;
    bus_start();
    send_byte(8'hCC, 1'b0);
    send_byte(8'h32, 1'b0);
    exp_wr.push_back({8'h32, 8'h33});
    send_byte(8'h33, 1'b0);
    bus_stop();
    settle_and_drain(name);
    check({name, " write count"}, 16'(n_wr - wr0), 16'd1);
    check({name, " reg_addr"}, 16'(reg_addr), 16'h33);
    check({name, " busy seen"}, 16'(busy_seen), 16'd1);
    check({name, " busy after stop"}, 16'(busy), 16'd0);
  endtask

  initial begin
    logic s;
    int   wr0;
    repeat (3) @(negedge clk);
    check("reset sda_oe", 16'(sda_oe), 16'd0);
    check("reset reg_addr", 16'(reg_addr), 16'd0);
    check("reset reg_wdata", 16'(reg_wdata), 16'd0);
    check("reset reg_wr_en", 16'(reg_wr_en), 16'd0);
    check("reset busy", 16'(busy), 16'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    write_test("t1");

    // Wrong address
    wr0 = n_wr;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    bus_start();
    send_byte(8'h5C, 1'b1);
    send_byte(8'h3C, 1'b1);
    bus_stop();
    settle_and_drain("t2");
    check("t2 sda never driven", 16'(oe_seen), 16'd0);
    check("t2 busy never set", 16'(busy_seen), 16'd0);
    check("t2 write count", 16'(n_wr - wr0), 16'd0);
    check("t2 reg_addr kept", 16'(reg_addr), 16'h33);

    // Random read with repeated START
    bus_start();
    send_byte(8'hCC, 1'b0);
    send_byte(8'h10, 1'b0);
    bus_start();
    send_byte(8'hCD, 1'b0);
    recv_byte(8'h4A, 1'b0);
    recv_byte(8'h4B, 1'b1);
    bus_stop();
    settle_and_drain("t3");
    check("t3 reg_addr", 16'(reg_addr), 16'h12);
    check("t3 busy after stop", 16'(busy), 16'd0);

    // Burst write wrapping the pointer
    bus_start();
    send_byte(8'hCC, 1'b0);
    send_byte(8'hFE, 1'b0);
    exp_wr.push_back({8'hFE, 8'hA1});
    send_byte(8'hA1, 1'b0);
    exp_wr.push_back({8'hFF, 8'hA2});
    send_byte(8'hA2, 1'b0);
    exp_wr.push_back({8'h00, 8'hA3});
    send_byte(8'hA3, 1'b0);
    bus_stop();
    settle_and_drain("t4");
    check("t4 reg_addr", 16'(reg_addr), 16'h01);

    // STOP after four data bits
    wr0 = n_wr;
    bus_start();
    send_byte(8'hCC, 1'b0);
    send_byte(8'h40, 1'b0);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    bus_stop();
    settle_and_drain("t5");
    check("t5 write count", 16'(n_wr - wr0), 16'd0);
    check("t5 state idle", 16'(dut.state_q), 16'(StIdle));
    check("t5 sda_oe", 16'(sda_oe), 16'd0);
    check("t5 busy", 16'(busy), 16'd0);
    check("t5 reg_addr", 16'(reg_addr), 16'h40);

    // Reset while the target drives the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'hCC >> i) & 8'h01) != 0, s);
    m_sda = 1'b1;
    #Q;
    check("t6 ack driven", 16'(sda_oe), 16'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 sda_oe after rst", 16'(sda_oe), 16'd0);
    check("t6 busy after rst", 16'(busy), 16'd0);
    check("t6 reg_addr after rst", 16'(reg_addr), 16'd0);
    m_scl = 1'b1; #(2 * Q);
    m_scl = 1'b0; #Q;
    bus_stop();
    repeat (4) @(negedge clk);
    write_test("t6 rerun");

    check("no new drive while scl high", 16'(viol), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
